// File: rtl/compare_arbiter_if.sv
// Requester-side bus of compare_arbiter.
//   rq_req : per-requester level request, held with operands until rq_ack
//   rq_x/y : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rq_ack : one-cycle one-hot completion pulse
//   rq_res : {bigger,equal,smaller}, valid with rq_ack
//   rq_err : timeout or malformed result, valid with rq_ack
interface compare_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  logic [N-1:0]       rq_req;
  logic [N*WIDTH-1:0] rq_x;
  logic [N*WIDTH-1:0] rq_y;
  logic [N-1:0]       rq_ack;
  logic [2:0]         rq_res;
  logic               rq_err;

  modport master (output rq_req, rq_x, rq_y, input  rq_ack, rq_res, rq_err);
  modport slave  (input  rq_req, rq_x, rq_y, output rq_ack, rq_res, rq_err);
endinterface

// File: rtl/compare_arbiter.sv
// Shares one asynchronous req/fin comparator among N clocked requesters.
// Round-robin grant, registered operands and cmp_req, 2-flop fin synchronizer,
// one-cycle ack carrying the one-hot compare result or an error.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   rq              : requester bus (slave side)
//   busy            : high whenever not idle
//   cmp_req/x/y     : registered request and operands to the comparator
//   cmp_fin         : asynchronous done from the comparator
//   cmp_bigger/equal/smaller : comparator result, stable while cmp_fin high
module compare_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  compare_arbiter_if.slave rq,
  output logic             busy,
  output logic             cmp_req,
  output logic [WIDTH-1:0] cmp_x,
  output logic [WIDTH-1:0] cmp_y,
  input  logic             cmp_fin,
  input  logic             cmp_bigger,
  input  logic             cmp_equal,
  input  logic             cmp_smaller
);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LAUNCH, S_WAIT_FIN, S_DONE, S_RECOVER
  } state_t;

  state_t           r_state, w_next;
  logic [IW-1:0]    r_ptr, r_grant, w_pick;
  logic             w_any;
  logic [CW-1:0]    r_cnt;
  logic             r_fin_s1, r_fin_s2;
  logic [2:0]       r_res;
  logic             r_to;
  logic             r_cmp_req;
  logic [WIDTH-1:0] r_cmp_x, r_cmp_y;
  logic             w_settled, w_expired, w_onehot_res;
  logic [N-1:0]     w_ack_vec;

  // Round-robin search from ptr+1 upward. Walking k downward lets the
  // smallest offset with a set request win the final assignment.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = N; k >= 1; k--) begin
      if (rq.rq_req[(int'(r_ptr) + k) % N]) begin
        w_any  = 1'b1;
        w_pick = IW'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_settled = (r_cnt == CW'(SETTLE - 1));
  assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

  // fin is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin_s1 <= 1'b0;
      r_fin_s2 <= 1'b0;
    end else begin
      r_fin_s1 <= cmp_fin;
      r_fin_s2 <= r_fin_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_any) w_next = S_SETUP;
      S_SETUP:    w_next = S_LAUNCH;
      S_LAUNCH:   if (w_settled) w_next = S_WAIT_FIN;
      S_WAIT_FIN: if (r_fin_s2 || w_expired) w_next = S_DONE;
      S_DONE:     w_next = S_RECOVER;
      S_RECOVER:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath. fin_s is ignored during LAUNCH: the previous operation's fin
  // may still be high there until the new req edge has cleared it and that
  // low level has crossed the synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_to      <= 1'b0;
      r_cmp_req <= 1'b0;
      r_cmp_x   <= '0;
      r_cmp_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant <= w_pick;
          r_cmp_x <= rq.rq_x[w_pick*WIDTH +: WIDTH];
          r_cmp_y <= rq.rq_y[w_pick*WIDTH +: WIDTH];
          r_cnt   <= '0;
          r_res   <= '0;
          r_to    <= 1'b0;
        end
        S_SETUP: begin
          r_cmp_req <= 1'b1;
          r_cnt     <= '0;
        end
        S_LAUNCH: r_cnt <= w_settled ? '0 : r_cnt + CW'(1);
        S_WAIT_FIN: begin
          if (r_fin_s2) begin
            r_res <= {cmp_bigger, cmp_equal, cmp_smaller};
          end else if (w_expired) begin
            r_res <= 3'b000;
            r_to  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_cmp_req <= 1'b0;
          r_ptr     <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign w_onehot_res = (r_res == 3'b100) || (r_res == 3'b010) || (r_res == 3'b001);
  assign w_ack_vec    = {{(N-1){1'b0}}, 1'b1} << r_grant;

  assign rq.rq_ack = (r_state == S_DONE) ? w_ack_vec : '0;
  assign rq.rq_res = (r_state == S_DONE) ? r_res : 3'b000;
  assign rq.rq_err = (r_state == S_DONE) && (r_to || !w_onehot_res);
  assign busy      = (r_state != S_IDLE);
  assign cmp_req   = r_cmp_req;
  assign cmp_x     = r_cmp_x;
  assign cmp_y     = r_cmp_y;
endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Clocked controller that shares one asynchronous comparator among N clocked requesters.
- The comparator is a req/fin block: a rising req clears its result and recomputes; fin stays high until the next rising req.
- The arbiter picks requesters round-robin, drives the comparator's operands and req, and waits for fin through a synchronizer.
- It returns a 3-bit one-hot result (or an error) to the granted requester with a one-cycle ack.

Parameters:
- Width, 32, operand width.
- N, 4, number of requesters (2..16).
- SETTLE, 2, cycles cmp_req is held high before fin is sampled; masks the stale-fin window.
- TIMEOUT, 64, cycles allowed in WAIT_FIN before abort.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- rq_req  input  N  per-requester level request; hold high with operands stable until rq_ack.
- rq_x  input  N*Width  operand x, requester i at bits [i*Width +: Width].
- rq_y  input  N*Width  operand y, same packing.
- rq_ack  output  N  one-cycle completion pulse, one-hot.
- rq_res  output  3  {bigger,equal,smaller}; valid only while rq_ack is nonzero.
- rq_err  output  1  valid with rq_ack; 1 = timeout or non-one-hot result.
- busy  output  1  high in every state except IDLE.
- cmp_req  output  1  registered request to the comparator.
- cmp_x, cmp_y  output  Width each  registered operands to the comparator.
- cmp_fin  input  1  asynchronous; through a 2-flop synchronizer reset to 0.
- cmp_bigger, cmp_equal, cmp_smaller  input  1 each  comparator result; stable while cmp_fin is high.

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, synchronizer 0. Asynchronous assert, synchronous release.
- Reset mid-operation: abandon the transaction, send no ack, drive cmp_req low. The comparator's stale result is harmless because the next rising cmp_req clears it.
- States: IDLE, SETUP, LAUNCH, WAIT_FIN, DONE, RECOVER.
- IDLE: if any rq_req is high, grant the first set bit searching from ptr+1 mod N upward.
  - Latch the grant index.
  - Load cmp_x/cmp_y from that requester's slice.
  - Go to SETUP. cmp_req stays 0.
- SETUP: one cycle so operands are stable before the req edge. Set cmp_req=1; go to LAUNCH.
- LAUNCH: hold cmp_req=1 for SETTLE cycles (counter), then go to WAIT_FIN. fin_s is ignored here.
- WAIT_FIN:
  - If fin_s==1, capture the three result bits and go to DONE.
  - Else increment the timeout counter. At TIMEOUT cycles, capture 000 with an error flag and go to DONE.
- DONE (one cycle):
  - rq_ack[grant]=1 and rq_res = captured bits.
  - rq_err=1 if timed out or the captured bits are not exactly one of 100/010/001.
  - cmp_req<=0; ptr<=grant; go to RECOVER.
- RECOVER: one cycle with cmp_req low so the next rising edge is guaranteed; then go to IDLE.
- Latency, no timeout: IDLE grant at edge 0, SETUP 1, LAUNCH 2..SETTLE+1, fin_s sampled from edge SETTLE+2, ack cycle ≥ SETTLE+3 after the request is seen.
- Back-to-back throughput: a new grant at the earliest 2 cycles after ack (RECOVER, then IDLE).
- Requester dropping rq_req before ack: the transaction completes and the ack still pulses.
- Operands are latched at grant, so later changes on rq_x/rq_y have no effect on the current operation.
- Simultaneous requests: strict round-robin; a requester held high is served within N transactions.
- A request arriving in any non-IDLE state waits.
- Only one rq_ack bit is ever high. rq_res and rq_err are 0 outside DONE.
- Operands are unsigned, passed through unmodified; no arithmetic in this block.

Test Plan:
- Single requester 0, x=5, y=3, behavioural comparator with 3 ns delay, SETTLE=2 → rq_ack[0] pulses exactly once, rq_res=100, rq_err=0, busy drops 2 cycles later.
- Requesters 0..3 all held high with x=y=7 from reset → grants in order 1,2,3,0 (ptr starts 0), each rq_res=010, no two acks within 5+SETTLE cycles.
- Requester 2 with x=0, y=0xFFFFFFFF, then x=0xFFFFFFFF, y=0 with fin still high from the previous op → results 001 then 100; the stale fin is masked by SETTLE.
- Comparator stub never asserts fin, TIMEOUT=64 → rq_ack pulses 64 cycles after entering WAIT_FIN, rq_res=000, rq_err=1, cmp_req low next cycle.
- Stub returns 110 with fin high → rq_err=1, rq_res=110.
- rst_n low during WAIT_FIN → all outputs 0 immediately, no ack. After release, a new request to requester 1 (x=9, y=4) completes with 100.
